demux_1to2_16bit: RTL and testbench
===================================

# demux_1to2_16bit

Sequential 1-to-2 stream demultiplexer. It is the inverse of the 2-to-1 select path: a single 16-bit input stream is steered, word by word, to one of two output channels chosen by `op`. Each channel has its own small buffer, so a stalled consumer on one channel never blocks traffic destined for the other. It sits downstream of the datapath result bus and feeds two independent consumers, for example the register write-back stage and a store queue.

## Interface
Parameters:
- `WIDTH`, 16, data word width.
- `DEPTH`, 2, entries per channel buffer. Power of two, minimum 2.
- `CNT_W`, 8, width of each per-channel transfer counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_op`  in  1  destination select: 0 selects channel 0, 1 selects channel 1.
- `in_valid`  in  1  input word and `in_op` are valid this cycle.
- `in_ready`  out  1  the selected channel can accept a word this cycle.
- `out0_data`  out  WIDTH  head word of channel 0.
- `out0_valid`  out  1  channel 0 is non-empty.
- `out0_ready`  in  1  channel 0 consumer accepts the head word.
- `out1_data`, `out1_valid`, `out1_ready`: same as channel 0, for channel 1.
- `cnt0`  out  CNT_W  words accepted into channel 0 since reset.
- `cnt1`  out  CNT_W  words accepted into channel 1 since reset.

## Operation
- Input accept occurs when `in_valid && in_ready` are both high. The word is written to the buffer of channel `in_op`.
- `in_ready = !full[in_op]`. It is combinational from `in_op` and buffer state only, and never depends on `outN_ready`. This means there is no pass-through when a buffer is full.
- `in_data` and `in_op` must stay stable while `in_valid` is high and `in_ready` is low. The source may change `in_op` while stalled; `in_ready` then reflects the newly selected channel.
- Output handshake: `outN_valid = !emptyN` and `outN_data` = head entry. A pop occurs when `outN_valid && outN_ready` are both high.
  - When a channel is empty, `outN_data` holds its last value (0 after reset).
- Ordering: each channel is strict FIFO. There is no ordering guarantee between channels.
- Simultaneous push and pop on the same channel:
  - The occupancy count is unchanged.
  - The pop always returns the old head.
  - When the channel holds 1 entry, the pushed word becomes the new head on the next cycle.
- Simultaneous pops on both channels and a push to either are all legal in the same cycle.
- Counters:
  - `cntN` increments by 1 on each accept into channel N.
  - Counters wrap modulo 2^CNT_W (255 -> 0 for the default width).
  - Counters are not affected by pops.
- Reset, including mid-operation:
  - Both buffers are flushed and pointers are zeroed.
  - `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`.
  - `cnt0 = cnt1 = 0`.
  - `in_ready = 1` from the first cycle after reset deasserts. During reset, `in_ready` is 0.
  - Words held before reset are lost and never appear at the outputs.
- `in_op` is ignored when `in_valid` is low.

## Timing
- Latency: a word accepted at edge k is visible with `outN_valid` high after edge k. That is one cycle from accept to availability.
- Throughput: one accept per cycle, provided the selected channel is not full.
  - With `DEPTH=2` and a consumer that asserts ready continuously, a single channel sustains 1 word/cycle.
- `in_ready` deasserts in the cycle after the accept that fills the channel. It reasserts in the cycle after the first pop from the full channel.
- All outputs are registered except `in_ready`, whose logic is one mux over two full flags.

## Structure
- Shared package `demux_pkg` holds:
  - `WIDTH`, `DEPTH`, `CNT_W` defaults;
  - the localparams `CH0 = 1'b0` and `CH1 = 1'b1`;
  - the pointer width `$clog2(DEPTH)`.
- The natural sub-module is `fifo_sync`, instantiated once per channel. It is parameterised by WIDTH and DEPTH and has:
  - write and read ports;
  - `full` and `empty` outputs;
  - a synchronous active-high `reset`.
- The top level contains the steering logic, the `in_ready` mux and the two counters.

## Test plan
- Reset mid-stream: push 0x1111 and 0x2222 to channel 0, then assert `reset` for 1 cycle -> `out0_valid = 0`, `out0_data = 0`, `cnt0 = 0`, `in_ready = 1` on the next cycle, and 0x1111 never emerges.
- Basic routing: push 0xA5A5 with op=0, then 0x5A5A with op=1, with both consumers ready -> 0xA5A5 on `out0` and 0x5A5A on `out1`, each one cycle after its accept; `cnt0 = 1`, `cnt1 = 1`.
- Full and independence: hold `out0_ready = 0` and push 0x0001, 0x0002, 0x0003 to channel 0 -> `in_ready` drops after 2 accepts. Switch `in_op` to 1 -> `in_ready = 1` and 0x0004 is delivered on `out1`. Release `out0_ready` -> 0x0001 then 0x0002, then 0x0003 is accepted.
- Simultaneous push and pop: channel 1 holds 1 entry (0x00AA), then push 0x00BB with `out1_ready = 1` in the same cycle -> 0x00AA pops and 0x00BB is the head next cycle; occupancy stays 1.
- Counter wrap: perform 256 accepts into channel 1 -> `cnt1` reads 255 after 255 accepts and 0 after 256; `cnt0` stays 0.
- Random back-pressure: 1000 random words with random op and random ready on each output -> a scoreboard confirms per-channel order, no loss or duplication, and `cntN` equals the accepted count mod 256.

Source files
------------

// File: rtl/demux_1to2_16bit_pkg.sv
// Shared defaults and channel encodings for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // A single-entry buffer still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned PTR_W = ptr_width(DEPTH);

endpackage

// File: rtl/demux_1to2_16bit_if.sv
// Stream bundle for the demux: one input stream, two output streams, two counters.
interface demux_1to2_16bit_if #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH,
  parameter int unsigned CNT_W = demux_pkg::CNT_W
);

  logic [WIDTH-1:0] in_data;
  logic             in_op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_data, in_op, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport slave (
    input  in_data, in_op, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

endinterface

// File: rtl/demux_1to2_16bit_fifo_sync.sv
// Synchronous FIFO with a registered head word that holds its last value when empty.
module fifo_sync #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH,
  parameter int unsigned DEPTH = demux_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW  = demux_pkg::ptr_width(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [WIDTH-1:0]  r_mem_q [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr_q, r_wr_ptr_d;
  logic [PtrW-1:0]   r_rd_ptr_q, r_rd_ptr_d;
  logic [CountW-1:0] r_count_q, r_count_d;
  logic [WIDTH-1:0]  r_rdata_q, r_rdata_d;
  logic              w_push, w_pop;

  assign o_full    = (r_count_q == CountW'(DEPTH));
  assign o_empty   = (r_count_q == '0);
  assign o_rd_data = r_rdata_q;
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;

  always_comb begin
    r_wr_ptr_d = w_push ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
    r_rd_ptr_d = w_pop  ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
    r_count_d  = r_count_q;
    case ({w_push, w_pop})
      2'b10:   r_count_d = r_count_q + 1'b1;
      2'b01:   r_count_d = r_count_q - 1'b1;
      default: r_count_d = r_count_q;
    endcase
    // Next head may be the word being written this very cycle.
    r_rdata_d = r_rdata_q;
    if (r_count_d != '0) begin
      if (w_push && (r_wr_ptr_q == r_rd_ptr_d)) begin
        r_rdata_d = i_wr_data;
      end else begin
        r_rdata_d = r_mem_q[r_rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr_q <= '0;
      r_rd_ptr_q <= '0;
      r_count_q  <= '0;
      r_rdata_q  <= '0;
    end else begin
      r_wr_ptr_q <= r_wr_ptr_d;
      r_rd_ptr_q <= r_rd_ptr_d;
      r_count_q  <= r_count_d;
      r_rdata_q  <= r_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_q[r_wr_ptr_q] <= i_wr_data;
    end
  end

endmodule

// File: rtl/demux_1to2_16bit.sv
// 1-to-2 stream demux: steers each input word into one of two independent channel FIFOs.
module demux_1to2_16bit #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH,
  parameter int unsigned DEPTH = demux_pkg::DEPTH,
  parameter int unsigned CNT_W = demux_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  demux_1to2_16bit_if.slave       bus
);

  import demux_pkg::*;

  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt0_q, r_cnt0_d;
  logic [CNT_W-1:0] r_cnt1_q, r_cnt1_d;

  // Held low during reset so nothing is accepted while the buffers are flushed.
  assign bus.in_ready = !reset && !w_full[bus.in_op];
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_push[0]    = w_accept && (bus.in_op == CH0);
  assign w_push[1]    = w_accept && (bus.in_op == CH1);
  assign w_pop[0]     = !w_empty[0] && bus.out0_ready;
  assign w_pop[1]     = !w_empty[1] && bus.out1_ready;

  assign bus.out0_valid = !w_empty[0];
  assign bus.out1_valid = !w_empty[1];
  assign bus.cnt0       = r_cnt0_q;
  assign bus.cnt1       = r_cnt1_q;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_ch0 (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_push[0]),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_pop[0]),
    .o_rd_data (bus.out0_data),
    .o_full    (w_full[0]),
    .o_empty   (w_empty[0])
  );

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_ch1 (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_push[1]),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_pop[1]),
    .o_rd_data (bus.out1_data),
    .o_full    (w_full[1]),
    .o_empty   (w_empty[1])
  );

  always_comb begin
    r_cnt0_d = w_push[0] ? r_cnt0_q + 1'b1 : r_cnt0_q;
    r_cnt1_d = w_push[1] ? r_cnt1_q + 1'b1 : r_cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0_q <= '0;
      r_cnt1_q <= '0;
    end else begin
      r_cnt0_q <= r_cnt0_d;
      r_cnt1_q <= r_cnt1_d;
    end
  end

endmodule

// File: tb/tb_demux_1to2_16bit.sv
// Bench for demux_1to2_16bit: directed vector table, reset/wrap sequences, random scoreboard run.
module tb_demux_1to2_16bit;
  import demux_pkg::*;

  typedef struct {
    logic        v;
    logic        op;
    logic [15:0] d;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic        e_v1;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  demux_1to2_16bit_if bus ();

  demux_1to2_16bit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] last0 = '0;
  logic [15:0] last1 = '0;
  logic [7:0]  m_cnt0 = '0;
  logic [7:0]  m_cnt1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: queues mirror each channel's buffer; events take effect at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      check("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
      q0.delete();
      q1.delete();
      last0  = '0;
      last1  = '0;
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      check("in_ready", 32'(bus.in_ready),
            32'(((bus.in_op ? q1.size() : q0.size()) < int'(DEPTH))));
      check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
      check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
      check("out0_data", 32'(bus.out0_data), 32'((q0.size() != 0) ? q0[0] : last0));
      check("out1_data", 32'(bus.out1_data), 32'((q1.size() != 0) ? q1[0] : last1));
      check("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
      check("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
      if (bus.out0_valid && bus.out0_ready && q0.size() != 0) last0 = q0.pop_front();
      if (bus.out1_valid && bus.out1_ready && q1.size() != 0) last1 = q1.pop_front();
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_op) begin
          q1.push_back(bus.in_data);
          m_cnt1++;
        end else begin
          q0.push_back(bus.in_data);
          m_cnt0++;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic op, input logic [15:0] d,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[16];
  int   acc0, acc1, accepted, cycles;
  logic cur_op;
  logic [15:0] cur_d;

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-stream: two words queued on channel 0 must vanish.
    drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("rst_out0_data", 32'(bus.out0_data), 32'h0);
    check("rst_cnt0", 32'(bus.cnt0), 32'd0);
    check("rst_in_ready_high", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      @(negedge clk);
      check("rst_no_stale_word", 32'(bus.out0_valid), 32'd0);
    end

    // Directed table: routing, full/independence, simultaneous push+pop on channel 1.
    tbl[0]  = '{1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 16'h00BB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].r0, tbl[i].r1);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_out0_valid", i), 32'(bus.out0_valid), 32'(tbl[i].e_v0));
      check($sformatf("tbl%0d_out1_valid", i), 32'(bus.out1_valid), 32'(tbl[i].e_v1));
      if (i == 13) check("tbl_pushpop_head", 32'(bus.out1_data), 32'h00BB);
    end
    check("tbl_cnt0", 32'(bus.cnt0), 32'd4);
    check("tbl_cnt1", 32'(bus.cnt1), 32'd4);

    // Counter wrap on channel 1.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 16'(i), 1'b0, 1'b1);
      if (i == 255) begin
        @(negedge clk);
        check("wrap_cnt1_255", 32'(bus.cnt1), 32'd255);
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("wrap_cnt1_0", 32'(bus.cnt1), 32'd0);
    check("wrap_cnt0_0", 32'(bus.cnt0), 32'd0);

    // Random traffic with back-pressure.
    do_reset();
    acc0     = 0;
    acc1     = 0;
    accepted = 0;
    cycles   = 0;
    cur_op   = 1'($urandom_range(0, 1));
    cur_d    = 16'($urandom);
    while (accepted < 1000 && cycles < 20000) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      drive(v, cur_op, cur_d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (v && bus.in_ready) begin
        accepted++;
        if (cur_op) acc1++;
        else acc0++;
        cur_op = 1'($urandom_range(0, 1));
        cur_d  = 16'($urandom);
      end
      cycles++;
    end
    check("rand_accepted", 32'(accepted), 32'd1000);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    end
    @(negedge clk);
    check("rand_drain_q0", 32'(q0.size()), 32'd0);
    check("rand_drain_q1", 32'(q1.size()), 32'd0);
    check("rand_cnt0", 32'(bus.cnt0), 32'(acc0 % 256));
    check("rand_cnt1", 32'(bus.cnt1), 32'(acc1 % 256));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
